uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Sequences the UART receiver output into 4-byte command frames: [SYNC][ADDR][DATA][CHK].
//  Validated frames write a 4 x 8-bit register bank. Malformed or stalled frames are counted as errors.
//  Sits directly downstream of the UART receiver; the bank drives board-level control signals.
// PARAMETERS
//  CLKS_PER_BIT  2000000  clocks per UART bit; must match the receiver; sets the timeout scale
//  TIMEOUT_BITS  20       inter-byte timeout, in bit periods (limit = TIMEOUT_BITS*CLKS_PER_BIT clocks)
//  SYNC_BYTE     8'hA5    frame start marker
// PORTS
//  Clk            in   1   system clock; all logic on posedge
//  Rst            in   1   synchronous, active-high reset
//  Rx_Data_Valid  in   1   receiver valid; level stretched for CLKS_PER_BIT clocks per byte
//  Rx_Byte        in   8   receiver byte; stable while Rx_Data_Valid is high
//  Reg_Out        out  32  register bank {R3,R2,R1,R0}
//  Wr_Strobe      out  1   1-clock pulse: register written
//  Wr_Addr        out  2   address of the last write; held between writes
//  Wr_Data        out  8   data of the last write; held between writes
//  Frame_Err      out  1   1-clock pulse: bad checksum or bad address
//  Timeout_Err    out  1   1-clock pulse: inter-byte timeout
//  Err_Count      out  8   total errors; saturates at 8'hFF
//  Busy           out  1   high when state != IDLE
// BEHAVIOUR
//  Reset
//   - All outputs are 0, bank is 0, state is IDLE, timeout counter is 0.
//   - dv_q is reset to 1, so a Valid already high at reset release is not a byte event.
//   - Reset mid-frame aborts the frame silently: no error, no count.
//  Byte event
//   - Occurs on any posedge with Rx_Data_Valid=1 and dv_q=0; dv_q <= Rx_Data_Valid every clock.
//   - Rx_Byte is captured in the event cycle. Exactly one event per received byte.
//  FSM (advances only on byte events, except timeout)
//   - IDLE: byte==SYNC_BYTE -> ADDR; any other byte is discarded, no error.
//   - ADDR: latch addr; bad_addr = |byte[7:2]; -> DATA. A bad address still consumes the frame.
//   - DATA: latch data; -> CHK.
//   - CHK: expected = SYNC_BYTE ^ addr ^ data; -> IDLE.
//       * byte==expected and !bad_addr: R[addr[1:0]] <= data; Wr_Addr/Wr_Data updated; Wr_Strobe=1.
//       * otherwise: Frame_Err=1 and Err_Count increments; bank unchanged.
//  Latency
//   - CHK event at edge N; Reg_Out, Wr_*, and the error pulse are visible after edge N+1.
//   - All outputs are registered.
//  Timeout
//   - Counter runs only in ADDR/DATA/CHK; clears on every byte event and in IDLE.
//   - On reaching TIMEOUT_BITS*CLKS_PER_BIT-1: Timeout_Err=1, Err_Count increments, -> IDLE.
//   - Byte event and timeout in the same cycle: the byte event wins and the counter clears.
//  Err_Count
//   - At most one increment per clock; holds at 8'hFF with no wrap.
//   - Errors still pulse Frame_Err/Timeout_Err when saturated.
//  Counter width
//   - The timeout counter is 32 bits; the product TIMEOUT_BITS*CLKS_PER_BIT must fit in 32 bits.
//  Back-to-back frames
//   - The SYNC of the next frame may arrive immediately after CHK; no dead cycles are required.
// TESTING (bench: CLKS_PER_BIT=4, TIMEOUT_BITS=20, so timeout = 80 clocks)
//  - Frame A5,02,3C,9B
//      -> one Wr_Strobe; Wr_Addr=2; Wr_Data=3C; Reg_Out=32'h003C0000; Err_Count=0.
//  - Frame A5,01,55,00 (bad checksum)
//      -> Frame_Err pulse; Err_Count=1; Reg_Out unchanged; no Wr_Strobe.
//  - Frame A5,05,11,B1 (valid checksum, addr>3)
//      -> Frame_Err pulse; Err_Count increments; bank unchanged.
//  - Send A5,00 then idle 100 clocks
//      -> Timeout_Err pulse exactly 80 clocks after the 00 event; Busy falls; next A5,00,7E,DB writes R0=7E.
//  - Noise bytes 00,FF,5A then a valid frame
//      -> noise causes no errors and no strobes; the valid frame writes.
//  - Hold Valid high across Rst release, then assert Rst mid-frame (after A5,03)
//      -> no byte event from the held Valid, no error, Busy=0, Err_Count=0.
//  - 300 bad-checksum frames
//      -> Err_Count saturates at FF; Frame_Err still pulses.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Frames UART receiver bytes into [SYNC][ADDR][DATA][CHK] commands that write a 4 x 8-bit bank.
// Checksum and address faults and inter-byte stalls are counted as errors (saturating at 8'hFF).
module uart_cmd_ctrl #(
  parameter int          CLKS_PER_BIT = 2000000,
  parameter int          TIMEOUT_BITS = 20,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Rx_Data_Valid,
  input  logic [7:0]  Rx_Byte,
  output logic [31:0] Reg_Out,
  output logic        Wr_Strobe,
  output logic [1:0]  Wr_Addr,
  output logic [7:0]  Wr_Data,
  output logic        Frame_Err,
  output logic        Timeout_Err,
  output logic [7:0]  Err_Count,
  output logic        Busy
);

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, CHK} state_t;

  state_t      r_state;
  logic        r_dv_q;
  logic [31:0] r_to_cnt;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic        r_bad_addr;
  logic        r_wr_pend;
  logic        r_err_pend;
  logic [31:0] r_reg_out;
  logic        r_wr_strobe;
  logic [1:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_frame_err;
  logic        r_to_err;
  logic [7:0]  r_err_count;
  logic        r_busy;

  logic w_byte_evt;
  logic w_to_hit;
  logic w_err_inc;

  assign w_byte_evt = Rx_Data_Valid & ~r_dv_q;
  assign w_to_hit   = (r_state != IDLE) && !w_byte_evt && (r_to_cnt == TO_LIMIT);
  assign w_err_inc  = r_err_pend | w_to_hit;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_dv_q      <= 1'b1;
      r_to_cnt    <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_bad_addr  <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_err_pend  <= 1'b0;
      r_reg_out   <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
      r_to_err    <= 1'b0;
      r_err_count <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_dv_q     <= Rx_Data_Valid;
      r_wr_pend  <= 1'b0;
      r_err_pend <= 1'b0;
      r_to_err   <= 1'b0;

      case (r_state)
        IDLE: begin
          r_to_cnt <= '0;
          if (w_byte_evt && Rx_Byte == SYNC_BYTE) begin
            r_state <= ADDR;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          if (w_byte_evt) begin
            r_to_cnt <= '0;
            case (r_state)
              ADDR: begin
                r_addr     <= Rx_Byte;
                r_bad_addr <= |Rx_Byte[7:2];
                r_state    <= DATA;
              end
              DATA: begin
                r_data  <= Rx_Byte;
                r_state <= CHK;
              end
              CHK: begin
                if (Rx_Byte == (SYNC_BYTE ^ r_addr ^ r_data) && !r_bad_addr)
                  r_wr_pend  <= 1'b1;
                else
                  r_err_pend <= 1'b1;
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
              default: ;
            endcase
          end else if (w_to_hit) begin
            r_to_err <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
      endcase

      // r_addr/r_data cannot change the cycle after CHK: the FSM is at best back in ADDR.
      r_wr_strobe <= r_wr_pend;
      r_frame_err <= r_err_pend;
      if (r_wr_pend) begin
        r_reg_out[{r_addr[1:0], 3'b000} +: 8] <= r_data;
        r_wr_addr <= r_addr[1:0];
        r_wr_data <= r_data;
      end

      if (w_err_inc && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign Reg_Out     = r_reg_out;
  assign Wr_Strobe   = r_wr_strobe;
  assign Wr_Addr     = r_wr_addr;
  assign Wr_Data     = r_wr_data;
  assign Frame_Err   = r_frame_err;
  assign Timeout_Err = r_to_err;
  assign Err_Count   = r_err_count;
  assign Busy        = r_busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with CLKS_PER_BIT=4, TIMEOUT_BITS=20 (80-clock timeout).
module tb_uart_cmd_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Rx_Data_Valid;
  logic [7:0]  Rx_Byte;
  logic [31:0] Reg_Out;
  logic        Wr_Strobe;
  logic [1:0]  Wr_Addr;
  logic [7:0]  Wr_Data;
  logic        Frame_Err;
  logic        Timeout_Err;
  logic [7:0]  Err_Count;
  logic        Busy;

  uart_cmd_ctrl #(.CLKS_PER_BIT(4), .TIMEOUT_BITS(20), .SYNC_BYTE(8'hA5)) dut (
    .Clk(Clk), .Rst(Rst), .Rx_Data_Valid(Rx_Data_Valid), .Rx_Byte(Rx_Byte),
    .Reg_Out(Reg_Out), .Wr_Strobe(Wr_Strobe), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Frame_Err(Frame_Err), .Timeout_Err(Timeout_Err), .Err_Count(Err_Count), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_strobe = 0, n_ferr = 0, n_terr = 0;
  int strobe_cyc = 0, terr_cyc = 0, last_evt = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Pulse counters sampled mid-cycle; a stretched pulse would be counted more than once.
  always @(negedge Clk) begin
    if (Wr_Strobe)   begin n_strobe++; strobe_cyc = cyc; end
    if (Frame_Err)   n_ferr++;
    if (Timeout_Err) begin n_terr++; terr_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clk);
    Rx_Data_Valid = 1'b1;
    Rx_Byte       = b;
    last_evt      = cyc + 1;
    repeat (4) @(negedge Clk);
    Rx_Data_Valid = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  int s0, f0, t0;

  initial begin
    Rst = 1'b1;
    Rx_Data_Valid = 1'b1;
    Rx_Byte = 8'hA5;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    repeat (10) @(negedge Clk);
    check("rst_reg_out", Reg_Out, 32'h0);
    check("rst_err_cnt", {24'h0, Err_Count}, 32'h0);
    check("held_valid_busy", {31'h0, Busy}, 32'h0);
    check("rst_wr_addr", {30'h0, Wr_Addr}, 32'h0);
    Rx_Data_Valid = 1'b0;
    repeat (2) @(negedge Clk);

    send_frame(8'h02, 8'h3C, 8'h9B);
    check("a_strobes", n_strobe, 1);
    check("a_latency", strobe_cyc - last_evt, 1);
    check("a_wr_addr", {30'h0, Wr_Addr}, 32'h2);
    check("a_wr_data", {24'h0, Wr_Data}, 32'h3C);
    check("a_reg_out", Reg_Out, 32'h003C0000);
    check("a_err_cnt", {24'h0, Err_Count}, 32'h0);

    send_frame(8'h01, 8'h55, 8'h00);
    check("badchk_ferr", n_ferr, 1);
    check("badchk_err_cnt", {24'h0, Err_Count}, 32'h1);
    check("badchk_reg_out", Reg_Out, 32'h003C0000);
    check("badchk_strobes", n_strobe, 1);

    send_frame(8'h05, 8'h11, 8'hB1);
    check("badaddr_ferr", n_ferr, 2);
    check("badaddr_err_cnt", {24'h0, Err_Count}, 32'h2);
    check("badaddr_reg_out", Reg_Out, 32'h003C0000);

    send_byte(8'hA5);
    send_byte(8'h00);
    check("to_busy_before", {31'h0, Busy}, 32'h1);
    repeat (100) @(negedge Clk);
    check("to_pulses", n_terr, 1);
    check("to_delay", terr_cyc - last_evt, 80);
    check("to_busy_after", {31'h0, Busy}, 32'h0);
    check("to_err_cnt", {24'h0, Err_Count}, 32'h3);
    send_frame(8'h00, 8'h7E, 8'hDB);
    check("to_recover_reg", Reg_Out, 32'h003C007E);

    s0 = n_strobe; f0 = n_ferr;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("noise_busy", {31'h0, Busy}, 32'h0);
    check("noise_ferr", n_ferr - f0, 0);
    check("noise_strobes", n_strobe - s0, 0);
    send_frame(8'h01, 8'h12, 8'hB6);
    check("noise_frame_reg", Reg_Out, 32'h003C127E);
    check("noise_frame_err_cnt", {24'h0, Err_Count}, 32'h3);

    f0 = n_ferr; t0 = n_terr;
    send_byte(8'hA5);
    send_byte(8'h03);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("midrst_busy", {31'h0, Busy}, 32'h0);
    check("midrst_err_cnt", {24'h0, Err_Count}, 32'h0);
    check("midrst_reg_out", Reg_Out, 32'h0);
    repeat (100) @(negedge Clk);
    check("midrst_no_ferr", n_ferr - f0, 0);
    check("midrst_no_terr", n_terr - t0, 0);

    f0 = n_ferr;
    for (int i = 0; i < 300; i++) send_frame(8'h01, 8'h55, 8'h00);
    check("sat_err_cnt", {24'h0, Err_Count}, 32'hFF);
    check("sat_ferr_pulses", n_ferr - f0, 300);
    check("sat_reg_out", Reg_Out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
